// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter: default parameter
//   values and the arbiter state encoding.
// -----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    localparam int DEFAULT_DW        = 3;
    localparam int DEFAULT_MAX_BURST = 4;

    // IDLE: nobody owns the write port; BUSYi: producer i owns it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of a FIFO between two producers using
//   round-robin arbitration with a bounded burst per grant. Words are only
//   taken while the FIFO is not full, so nothing is lost or written twice.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   req0 / data0   producer 0 request (held until ack0) and word
//   req1 / data1   producer 1 request (held until ack1) and word
//   fifo_full      FIFO full flag
//   ack0 / ack1    word from producer i taken this cycle (combinational)
//   fifo_wr        FIFO write strobe, ack0 | ack1
//   fifo_data      granted producer's word, 0 when idle
//   grant_id       granted producer, 0 when idle
//   busy           a producer currently holds the grant
//   dbg_state_o    current arbiter state
//   dbg_last_id_o  producer that held the most recently ended grant
//
// Handshake: producer i raises req_i with a stable word on data_i and holds
// both until the cycle where ack_i is high; the FIFO samples fifo_wr and
// fifo_data at the clock edge that ends that cycle. A producer may drop
// req_i without an ack; the word is then simply not taken.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    input  logic          fifo_full,
    output logic          ack0,
    output logic          ack1,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_data,
    output logic          grant_id,
    output logic          busy,
    output state_t        dbg_state_o,
    output logic          dbg_last_id_o
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic          last_id_q, last_id_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_id_q   <= 1'b1;   // producer 0 wins the first tie
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        ack0        = 1'b0;
        ack1        = 1'b0;
        fifo_data   = '0;
        grant_id    = 1'b0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (req0 && req1) begin
                    // Tie goes to whoever did not own the last grant.
                    state_d = last_id_q ? ST_BUSY0 : ST_BUSY1;
                end else if (req0) begin
                    state_d = ST_BUSY0;
                end else if (req1) begin
                    state_d = ST_BUSY1;
                end
            end

            ST_BUSY0: begin
                busy      = 1'b1;
                grant_id  = 1'b0;
                fifo_data = data0;
                ack0      = req0 && !fifo_full;
                if (!req0) begin
                    last_id_d   = 1'b0;
                    burst_cnt_d = '0;
                    state_d     = req1 ? ST_BUSY1 : ST_IDLE;
                end else if (ack0) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        // Burst exhausted: hand over if the other side waits,
                        // otherwise keep the grant with a fresh burst.
                        last_id_d   = 1'b0;
                        burst_cnt_d = '0;
                        state_d     = req1 ? ST_BUSY1 : ST_BUSY0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end

            ST_BUSY1: begin
                busy      = 1'b1;
                grant_id  = 1'b1;
                fifo_data = data1;
                ack1      = req1 && !fifo_full;
                if (!req1) begin
                    last_id_d   = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = req0 ? ST_BUSY0 : ST_IDLE;
                end else if (ack1) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        last_id_d   = 1'b1;
                        burst_cnt_d = '0;
                        state_d     = req0 ? ST_BUSY0 : ST_BUSY1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    assign fifo_wr       = ack0 | ack1;
    assign dbg_state_o   = state_q;
    assign dbg_last_id_o = last_id_q;

endmodule
